sample_rx: RTL and testbench
============================

SAMPLE_RX -- requirements
Module: sample_rx

Interface
REQ-001: Parameter BW, default 16, sample width in bits (the filter input width).
REQ-002: Parameter SYNC_STAGES, default 2, synchroniser depth for the serial pins, legal range 2..3.
REQ-003: clk_i  input  1  system clock; one clock, all state on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: sclk_i  input  1  serial bit clock, asynchronous to clk_i.
REQ-006: cs_n_i  input  1  frame select, active-low, asynchronous.
REQ-007: sdi_i  input  1  serial data, MSB first.
REQ-008: sample_o  output  BW  signed sample, held between updates; feeds the FIR input.
REQ-009: valid_o  output  1  one-cycle pulse when sample_o takes a new value.
REQ-010: err_o  output  1  one-cycle pulse on an aborted or rejected frame.

Function
REQ-011: sclk_i, cs_n_i and sdi_i shall each pass through SYNC_STAGES flops before any use.
REQ-012: A bit event shall be the clk_i cycle in which synchronised sclk is 1 and its previous value was 0.
REQ-013: FSM states: IDLE, SHIFT, DONE.
REQ-014: IDLE->SHIFT when synchronised cs_n is 0; the bit counter and shift register clear on entry.
REQ-015: In SHIFT, each bit event shall shift synchronised sdi into the LSB and increment the counter.
REQ-016: When the counter reaches FRAME_LEN, SHIFT->DONE.
- FRAME_LEN = BW without the parity option, BW+1 with it.
- sample_o loads the first BW bits on the same clock edge.
- valid_o = 1 for exactly the following cycle.
REQ-017: In DONE, further bit events shall be ignored; DONE->IDLE when synchronised cs_n is 1.
REQ-018: Synchronised cs_n rising while in SHIFT (short frame) shall return to IDLE, leave sample_o unchanged, suppress valid_o and pulse err_o for one cycle.
REQ-019: Latency from the final sclk pin rise to valid_o high shall be SYNC_STAGES+2 clk_i cycles.
REQ-020: sample_o shall be a zero-order hold: it changes only on a completed, accepted frame.
REQ-021: Bit events occurring while cs_n is high shall have no effect.
REQ-022: cs_n rising and the final bit event in the same cycle shall complete the frame (valid_o pulses), then go to IDLE.
REQ-023: sclk_i shall be at most clk_i/4; a faster sclk_i is outside specification.

Reset
REQ-024: rst_n low shall asynchronously force:
- state IDLE;
- counter 0, shift register 0;
- sample_o 0, valid_o 0, err_o 0;
- all synchroniser flops to 1 for cs_n and 0 for sclk and sdi.
REQ-025: Reset asserted mid-frame shall discard the partial frame; the first frame after release starts from IDLE.

Configuration
REQ-026: Macro SAMPLE_RX_PARITY_EN.
- When defined: FRAME_LEN = BW+1, and the final bit is even parity over all BW+1 bits. On a mismatch, sample_o holds, valid_o is suppressed and err_o pulses on the completion cycle.
- When undefined: FRAME_LEN = BW, and no parity logic exists.

Structure
REQ-027: Shared package dac_pkg shall hold:
- the BW default (16);
- the FSM state enum;
- the SYNC_STAGES default.
REQ-028: One sub-module, sync_edge: an SYNC_STAGES-deep synchroniser with rising-edge output, instantiated for sclk and reused without the edge output for cs_n and sdi.

Verification
REQ-029: Frame 0x7FFF, sclk = clk/8 -> sample_o = 0x7FFF, valid_o pulses exactly once, SYNC_STAGES+2 cycles after the last sclk rise.
REQ-030: Frame 0x8000 following 0x1234 -> sample_o 0x1234 then 0x8000, two valid_o pulses, sample_o constant between them.
REQ-031: cs_n raised after 9 bits of 0xABCD -> err_o pulses once, no valid_o, sample_o keeps the prior value.
REQ-032: 20 sclk pulses within one cs_n low window, data 0x00F0 then 4 extra bits -> one valid_o, sample_o = 0x00F0.
REQ-033: rst_n pulsed low for 1 cycle after 8 bits -> outputs 0 immediately; the next full frame 0x0001 yields sample_o = 0x0001.
REQ-034: With SAMPLE_RX_PARITY_EN defined:
- 0x0003 with parity bit 0 -> accepted;
- the same frame with parity bit 1 -> err_o pulse, sample_o unchanged.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared defaults and FSM state type for the serial sample receiver.
package dac_pkg;

    localparam int unsigned BW_DEFAULT          = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with an optional rising-edge pulse.
module sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0,
    parameter bit          EDGE_EN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

    if (EDGE_EN) begin : gen_edge
        logic prev_q;

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= RST_VAL;
            end else begin
                prev_q <= dout;
            end
        end

        assign rise = dout & ~prev_q;
    end else begin : gen_no_edge
        assign rise = 1'b0;
    end

endmodule

// File: rtl/sample_rx.sv
// Serial sample receiver: deserialises an MSB-first bit stream into held BW-bit signed samples.
// Defining SAMPLE_RX_PARITY_EN adds a trailing even-parity bit to every frame.
module sample_rx
    import dac_pkg::*;
#(
    parameter int unsigned BW          = BW_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 sclk_i,
    input  logic                 cs_n_i,
    input  logic                 sdi_i,
    output logic signed [BW-1:0] sample_o,
    output logic                 valid_o,
    output logic                 err_o
);

`ifdef SAMPLE_RX_PARITY_EN
    localparam int unsigned FRAME_LEN = BW + 1;
`else
    localparam int unsigned FRAME_LEN = BW;
`endif
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);

    logic unused_sclk_lvl;
    logic unused_rise_cs;
    logic unused_rise_sdi;
    logic sclk_rise;
    logic cs_n_s;
    logic sdi_s;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic signed [BW-1:0] sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 frame_full;

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0),
        .EDGE_EN (1'b1)
    ) u_sync_sclk (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .din   (sclk_i),
        .dout  (unused_sclk_lvl),
        .rise  (sclk_rise)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1),
        .EDGE_EN (1'b0)
    ) u_sync_cs_n (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .din   (cs_n_i),
        .dout  (cs_n_s),
        .rise  (unused_rise_cs)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0),
        .EDGE_EN (1'b0)
    ) u_sync_sdi (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .din   (sdi_i),
        .dout  (sdi_s),
        .rise  (unused_rise_sdi)
    );

    assign frame_full = (cnt_q == CW'(FRAME_LEN));

    // Completion has priority over the cs_n abort so a final bit landing with cs_n rising still
    // yields a sample.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!cs_n_s) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            StShift: begin
                if (frame_full) begin
                    state_d = StDone;
`ifdef SAMPLE_RX_PARITY_EN
                    if (^shift_q) begin
                        err_d = 1'b1;
                    end else begin
                        sample_d = $signed(shift_q[FRAME_LEN-1:1]);
                        valid_d  = 1'b1;
                    end
`else
                    sample_d = $signed(shift_q);
                    valid_d  = 1'b1;
`endif
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_LEN-2:0], sdi_s};
                    cnt_d   = cnt_q + 1'b1;
                end else if (cs_n_s) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shift_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sample_rx.sv
// Self-checking bench for sample_rx: directed frame table, corner sequences, random frames.
module tb_sample_rx;

    localparam int BW   = 16;
    localparam int SYNC = 2;
`ifdef SAMPLE_RX_PARITY_EN
    localparam int FLEN = BW + 1;
`else
    localparam int FLEN = BW;
`endif

    typedef struct {
        logic [BW-1:0] data;
        int            n_data;
        int            n_extra;
        bit            bad_par;
        int            half;
        bit            raise_last;
        logic [BW-1:0] exp_sample;
        int            exp_valid;
        int            exp_err;
    } vec_t;

    logic          clk_i  = 1'b0;
    logic          rst_n  = 1'b0;
    logic          sclk_i = 1'b0;
    logic          cs_n_i = 1'b1;
    logic          sdi_i  = 1'b0;
    logic [BW-1:0] sample_o;
    logic          valid_o;
    logic          err_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int last_rise_cyc = 0;
    logic [BW-1:0] prev_sample = '0;
    logic [BW-1:0] model_sample = '0;
    bit bits_q[$];
    vec_t tbl[$];

    sample_rx #(
        .BW          (BW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .sclk_i   (sclk_i),
        .cs_n_i   (cs_n_i),
        .sdi_i    (sdi_i),
        .sample_o (sample_o),
        .valid_o  (valid_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse counters and zero-order-hold watch, sampled mid-cycle.
    initial forever begin
        @(negedge clk_i);
        if (!rst_n) begin
            prev_sample = '0;
        end else begin
            if (valid_o) begin
                valid_cnt++;
                valid_cyc = cyc;
            end
            if (err_o) err_cnt++;
            if (sample_o !== prev_sample) check("sample_changes_only_with_valid", 32'(valid_o), 1);
            prev_sample = sample_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bits(input int half, input bit raise_last, input bit leave_open);
        cs_n_i = 1'b0;
        wait_clks(SYNC + 3);
        foreach (bits_q[i]) begin
            sdi_i = bits_q[i];
            wait_clks(half);
            sclk_i = 1'b1;
            if (i == FLEN - 1) last_rise_cyc = cyc;
            if (raise_last && i == bits_q.size() - 1) cs_n_i = 1'b1;
            wait_clks(half);
            sclk_i = 1'b0;
        end
        if (!leave_open) begin
            wait_clks(SYNC + 4);
            cs_n_i = 1'b1;
            wait_clks(SYNC + 4);
        end
    endtask

    // Reference: a frame is accepted iff cs_n saw at least FLEN bits and, with parity,
    // the first FLEN bits XOR to zero; the sample is the first BW bits, MSB first.
    task automatic model(output logic [BW-1:0] exp_s, output int ev, output int ee);
        logic [BW-1:0] v;
        bit par;
        v   = '0;
        par = 1'b0;
        ev  = 0;
        ee  = 1;
        if (bits_q.size() >= FLEN) begin
            for (int i = 0; i < BW; i++) v = {v[BW-2:0], bits_q[i]};
            for (int i = 0; i < FLEN; i++) par ^= bits_q[i];
            if (FLEN == BW || !par) begin
                ev = 1;
                ee = 0;
                model_sample = v;
            end
        end
        exp_s = model_sample;
    endtask

    task automatic run_frame(input int half, input bit raise_last, input logic [BW-1:0] exp_s,
                             input int ev, input int ee, input string tag);
        int v0;
        int e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(half, raise_last, 1'b0);
        check({tag, "_valid_pulses"}, 32'(valid_cnt - v0), 32'(ev));
        check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'(ee));
        check({tag, "_sample"}, 32'(sample_o), 32'(exp_s));
        if (ev == 1) check({tag, "_latency"}, 32'(valid_cyc - last_rise_cyc), 32'(SYNC + 2));
        model_sample = exp_s;
    endtask

    task automatic build(input logic [BW-1:0] d, input int nd, input bit bad_par, input int ne);
        bits_q.delete();
        for (int i = 0; i < nd; i++) bits_q.push_back(d[BW-1-i]);
        if (nd == BW && FLEN > BW) bits_q.push_back((^d) ^ bad_par);
        for (int i = 0; i < ne; i++) bits_q.push_back(i[0]);
    endtask

    function automatic vec_t mk(input logic [BW-1:0] d, input int nd, input int ne, input bit bp,
                                input int h, input bit rl, input logic [BW-1:0] es,
                                input int ev, input int ee);
        vec_t t;
        t.data = d;   t.n_data = nd; t.n_extra = ne; t.bad_par = bp; t.half = h;
        t.raise_last = rl; t.exp_sample = es; t.exp_valid = ev; t.exp_err = ee;
        return t;
    endfunction

    initial begin
        logic [BW-1:0] d;
        logic [BW-1:0] exp_s;
        int nd;
        int ne;
        int ev;
        int ee;
        int v0;
        int e0;
        bit bp;

        tbl.push_back(mk(16'h7FFF, 16, 0, 1'b0, 4, 1'b0, 16'h7FFF, 1, 0));
        tbl.push_back(mk(16'h1234, 16, 0, 1'b0, 4, 1'b0, 16'h1234, 1, 0));
        tbl.push_back(mk(16'h8000, 16, 0, 1'b0, 4, 1'b0, 16'h8000, 1, 0));
        tbl.push_back(mk(16'hABCD,  9, 0, 1'b0, 4, 1'b0, 16'h8000, 0, 1));
        tbl.push_back(mk(16'h00F0, 16, 4, 1'b0, 4, 1'b0, 16'h00F0, 1, 0));
        tbl.push_back(mk(16'h4321, 16, 0, 1'b0, 2, 1'b1, 16'h4321, 1, 0));
        tbl.push_back(mk(16'hFFFF, 16, 0, 1'b0, 2, 1'b0, 16'hFFFF, 1, 0));
        tbl.push_back(mk(16'h5555,  0, 0, 1'b0, 3, 1'b0, 16'hFFFF, 0, 1));
        tbl.push_back(mk(16'hA5A5, 15, 0, 1'b0, 3, 1'b1, 16'hFFFF, 0, 1));
`ifdef SAMPLE_RX_PARITY_EN
        tbl.push_back(mk(16'h0003, 16, 0, 1'b0, 4, 1'b0, 16'h0003, 1, 0));
        tbl.push_back(mk(16'h0003, 16, 0, 1'b1, 4, 1'b0, 16'h0003, 0, 1));
`endif
        tbl.push_back(mk(16'h0000, 16, 0, 1'b0, 2, 1'b0, 16'h0000, 1, 0));

        rst_n = 1'b0;
        wait_clks(3);
        check("reset_sample", 32'(sample_o), 0);
        check("reset_valid", 32'(valid_o), 0);
        check("reset_err", 32'(err_o), 0);
        rst_n = 1'b1;
        wait_clks(SYNC + 2);

        foreach (tbl[k]) begin
            build(tbl[k].data, tbl[k].n_data, tbl[k].bad_par, tbl[k].n_extra);
            run_frame(tbl[k].half, tbl[k].raise_last, tbl[k].exp_sample, tbl[k].exp_valid,
                      tbl[k].exp_err, $sformatf("tbl%0d", k));
        end

        // sclk activity with cs_n high must be ignored.
        v0 = valid_cnt;
        e0 = err_cnt;
        sdi_i = 1'b1;
        for (int i = 0; i < FLEN + 2; i++) begin
            wait_clks(2);
            sclk_i = 1'b1;
            wait_clks(2);
            sclk_i = 1'b0;
        end
        wait_clks(SYNC + 4);
        check("csn_high_valid", 32'(valid_cnt - v0), 0);
        check("csn_high_err", 32'(err_cnt - e0), 0);
        check("csn_high_sample", 32'(sample_o), 32'(model_sample));

        for (int k = 0; k < 30; k++) begin
            d  = BW'($urandom);
            nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BW - 1)) : BW;
            bp = ($urandom_range(0, 3) == 0);
            ne = (nd == BW) ? int'($urandom_range(0, 3)) : 0;
            build(d, nd, bp, ne);
            model(exp_s, ev, ee);
            run_frame(int'($urandom_range(2, 5)), ($urandom_range(0, 4) == 0), exp_s, ev, ee,
                      $sformatf("rnd%0d", k));
        end

        // Reset mid-frame after 8 bits, then a clean frame.
        build(16'h1234, 16, 1'b0, 0);
        run_frame(4, 1'b0, 16'h1234, 1, 0, "pre_reset");
        build(16'hC3C3, 8, 1'b0, 0);
        send_bits(4, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_sample", 32'(sample_o), 0);
        check("midreset_valid", 32'(valid_o), 0);
        check("midreset_err", 32'(err_o), 0);
        cs_n_i = 1'b1;
        wait_clks(1);
        rst_n = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_clks(SYNC + 4);
        check("post_reset_no_err", 32'(err_cnt - e0), 0);
        check("post_reset_no_valid", 32'(valid_cnt - v0), 0);
        model_sample = '0;
        build(16'h0001, 16, 1'b0, 0);
        run_frame(4, 1'b0, 16'h0001, 1, 0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
